riscv_instr_aligner: RTL

//  IF-stage realigner between the prefetch buffer and riscv_pre_decoder.

---
 rtl/riscv_defines.sv | 17 +
 rtl/riscv_instr_aligner_if.sv | 40 ++++
 rtl/riscv_instr_aligner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared types and helpers for the IF-stage instruction realigner.
// Provides the aligner state encoding and the RVC halfword test.
package riscv_defines;

  typedef enum logic [1:0] {
    ALIGNED    = 2'd0,
    MISALIGNED = 2'd1,
    BRANCH_MIS = 2'd2
  } align_state_e;

  function automatic logic is_compressed(
    input logic [15:0] h
  );
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_instr_aligner_if.sv
// Handshake bundle around the realigner: fetch side, ID side, redirect.
// slave = aligner view; master = prefetch/ID/controller view.
interface riscv_instr_aligner_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        instr_compressed_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  modport slave (
    input  fetch_valid_i,
    input  fetch_rdata_i,
    output fetch_ready_o,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_addr_o,
    output instr_compressed_o,
    input  branch_i,
    input  branch_addr_i
  );

  modport master (
    output fetch_valid_i,
    output fetch_rdata_i,
    input  fetch_ready_o,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_addr_o,
    input  instr_compressed_o,
    output branch_i,
    output branch_addr_i
  );
endinterface

// File: rtl/riscv_instr_aligner.sv
// Realigns word fetches into one RVC/32-bit instruction per handshake.
// Ports: clk, rst_n, bus (slave): fetch in, instr out, branch redirect.
module riscv_instr_aligner
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_instr_aligner_if.slave  bus
);

  align_state_e state_q, state_d;
  logic [15:0]  res_q, res_d;
  logic [31:0]  pc_q, pc_d;

  logic [15:0] lo, hi;
  logic        valid, fready, comp, fire;
  logic [31:0] instr;

  logic unused_addr0;
  assign unused_addr0 = bus.branch_addr_i[0];

  assign lo = bus.fetch_rdata_i[15:0];
  assign hi = bus.fetch_rdata_i[31:16];

  always_comb begin
    valid   = 1'b0;
    fready  = 1'b0;
    comp    = 1'b0;
    instr   = 32'h0;
    state_d = state_q;
    res_d   = res_q;
    unique case (state_q)
      ALIGNED: begin
        if (bus.fetch_valid_i) begin
          valid = 1'b1;
          if (is_compressed(lo)) begin
            instr = {16'h0, lo};
            comp  = 1'b1;
            if (bus.instr_ready_i) begin
              fready  = 1'b1;
              res_d   = hi;
              state_d = MISALIGNED;
            end
          end else begin
            instr  = bus.fetch_rdata_i;
            fready = bus.instr_ready_i;
          end
        end
      end
      MISALIGNED: begin
        if (is_compressed(res_q)) begin
          valid = 1'b1;
          comp  = 1'b1;
          instr = {16'h0, res_q};
          if (bus.instr_ready_i)
            state_d = ALIGNED;
        end else if (bus.fetch_valid_i) begin
          valid = 1'b1;
          instr = {lo, res_q};
          if (bus.instr_ready_i) begin
            fready = 1'b1;
            res_d  = hi;
          end
        end
      end
      BRANCH_MIS: begin
        if (bus.fetch_valid_i) begin
          if (is_compressed(hi)) begin
            valid = 1'b1;
            comp  = 1'b1;
            instr = {16'h0, hi};
            if (bus.instr_ready_i) begin
              fready  = 1'b1;
              state_d = ALIGNED;
            end
          end else begin
            // Upper half starts a straddling instr: bank it
            fready  = 1'b1;
            res_d   = hi;
            state_d = MISALIGNED;
          end
        end
      end
      default: state_d = ALIGNED;
    endcase

    if (bus.branch_i) begin
      valid   = 1'b0;
      fready  = 1'b0;
      res_d   = 16'h0;
      state_d = bus.branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
    end
  end

  assign fire = valid & bus.instr_ready_i;

  always_comb begin
    pc_d = pc_q;
    if (bus.branch_i)
      pc_d = {bus.branch_addr_i[31:1], 1'b0};
    else if (fire)
      pc_d = pc_q + (comp ? 32'd2 : 32'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIGNED;
      res_q   <= 16'h0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are forced quiet while reset is held
  assign bus.instr_valid_o      = rst_n & valid;
  assign bus.fetch_ready_o      = rst_n & fready;
  assign bus.instr_compressed_o = rst_n & comp;
  assign bus.instr_o            = rst_n ? instr : 32'h0;
  assign bus.instr_addr_o       = pc_q;

endmodule
